sine_monitor: RTL

//  Receive-side checker for the sine DAC sample stream: consumes 10-bit two's-complement samples
//  (same format the sine generator drives onto D0..D9), detects rising zero crossings with

---
 rtl/sine_monitor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sine_monitor.sv
// Receive-side checker for the sine DAC sample stream. It finds rising zero crossings
// with hysteresis and measures the period in samples and the peaks within each period.
module sine_monitor #(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned HYST         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   sample,
  output logic                    result_valid,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [DATA_WIDTH-1:0]   peak_pos,
  output logic [DATA_WIDTH-1:0]   peak_neg,
  output logic                    locked,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM_LOW,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0]   LP_HYST_POS = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0]   LP_HYST_NEG = -LP_HYST_POS;
  localparam logic        [PERIOD_WIDTH-1:0] LP_CNT_MAX  = '1;

  state_t                          r_state;
  state_t                          w_state_next;
  logic        [PERIOD_WIDTH-1:0]  r_cnt;
  logic signed [DATA_WIDTH-1:0]    r_max;
  logic signed [DATA_WIDTH-1:0]    r_min;
  logic                            r_result_valid;
  logic        [PERIOD_WIDTH-1:0]  r_period;
  logic signed [DATA_WIDTH-1:0]    r_peak_pos;
  logic signed [DATA_WIDTH-1:0]    r_peak_neg;
  logic                            r_locked;
  logic                            r_overflow;

  logic signed [DATA_WIDTH-1:0]    w_sample;
  logic                            w_is_low;
  logic                            w_is_high;
  logic                            w_counting;
  logic                            w_crossing;
  logic                            w_emit;
  logic                            w_timeout;
  logic        [PERIOD_WIDTH-1:0]  w_cnt_inc;

  always_comb begin
    w_sample  = sample;
    w_is_low  = (w_sample <= LP_HYST_NEG);
    w_is_high = (w_sample >= LP_HYST_POS);
    w_cnt_inc = (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + PERIOD_WIDTH'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timeout is derived from the registered count, so it is checked ahead of the
  // ordinary HIGH->LOW move; a crossing sample never times out.
  always_comb begin
    w_state_next = r_state;
    if (sample_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_low) w_state_next = S_ARM_LOW;
        end
        S_ARM_LOW: begin
          if (w_is_high) w_state_next = S_HIGH;
        end
        S_HIGH: begin
          if (w_timeout)     w_state_next = S_IDLE;
          else if (w_is_low) w_state_next = S_LOW;
        end
        S_LOW: begin
          if (w_is_high)      w_state_next = S_HIGH;
          else if (w_timeout) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Per-state decode of the current sample
  always_comb begin
    w_counting = (r_state == S_HIGH) || (r_state == S_LOW);
    w_crossing = sample_valid && w_is_high &&
                 ((r_state == S_ARM_LOW) || (r_state == S_LOW));
    w_emit     = sample_valid && w_is_high && (r_state == S_LOW);
    w_timeout  = sample_valid && w_counting && !w_crossing && (w_cnt_inc == LP_CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_max          <= '0;
      r_min          <= '0;
      r_result_valid <= 1'b0;
      r_period       <= '0;
      r_peak_pos     <= '0;
      r_peak_neg     <= '0;
      r_locked       <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_result_valid <= w_emit;
      if (w_emit) begin
        r_period   <= r_cnt;
        r_peak_pos <= r_max;
        r_peak_neg <= r_min;
        r_locked   <= 1'b1;
      end
      if (w_timeout) begin
        r_overflow <= 1'b1;
        r_locked   <= 1'b0;
      end
      // The crossing sample opens the next window, so it reloads rather than accumulates.
      if (w_crossing) begin
        r_cnt <= PERIOD_WIDTH'(1);
        r_max <= w_sample;
        r_min <= w_sample;
      end else if (w_timeout) begin
        r_cnt <= '0;
      end else if (sample_valid && w_counting) begin
        r_cnt <= w_cnt_inc;
        if (w_sample > r_max) r_max <= w_sample;
        if (w_sample < r_min) r_min <= w_sample;
      end
    end
  end

  always_comb begin
    result_valid = r_result_valid;
    period       = r_period;
    peak_pos     = r_peak_pos;
    peak_neg     = r_peak_neg;
    locked       = r_locked;
    overflow     = r_overflow;
  end

endmodule
